// File: rtl/branch_requester.sv
// branch_requester: initiator side of the branch-predictor request/result
// protocol. Actual branch outcomes arrive on a valid/ready stream into a small
// FIFO. For each one the block issues a request and captures the predictor's
// answer. It then waits RESOLVE_LAT cycles and returns result/taken, while
// keeping saturating resolved/mispredict counts.
//
// Parameters:
//   DEPTH       outcome FIFO entries (power of 2, >= 2)
//   RESOLVE_LAT idle cycles between prediction capture and result (0 allowed)
//   CNT_W       statistics counter width
//
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   in_valid/in_taken    outcome stream input
//   in_ready             FIFO not full
//   request              one-cycle prediction request
//   prediction           predictor answer, valid the cycle after request
//   result/taken         one-cycle resolution strobe and resolved outcome
//   busy                 transaction in flight
//   miss_pulse           prediction differed from outcome (with result)
//   total_cnt/miss_cnt   saturating resolved / mispredicted counts
//   max_streak           longest run of consecutive misses (MISS_STREAK_EN only)
//
// Optional feature macro: MISS_STREAK_EN adds the miss-streak tracker and the
// max_streak output.

module branch_requester #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RESOLVE_LAT = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_taken,
  output logic             in_ready,
  output logic             request,
  input  logic             prediction,
  output logic             result,
  output logic             taken,
  output logic             busy,
  output logic             miss_pulse,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
`ifdef MISS_STREAK_EN
  ,
  output logic [CNT_W-1:0] max_streak
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned LAT_W = (RESOLVE_LAT > 1) ? $clog2(RESOLVE_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_CAPT    = 3'd2,
    S_RESOLVE = 3'd3,
    S_RES     = 3'd4
  } state_e;

  // Saturating increment shared by all statistics registers.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic               mem_q [DEPTH];
  logic               mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               cur_taken_q, cur_taken_d;
  logic               pred_q, pred_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   total_cnt_q, total_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               request_q, request_d;
  logic               result_q, result_d;
  logic               taken_q, taken_d;
  logic               busy_q, busy_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               push, pop;

`ifdef MISS_STREAK_EN
  logic [CNT_W-1:0]   cur_streak_q, cur_streak_d;
  logic [CNT_W-1:0]   max_streak_q, max_streak_d;
  logic [CNT_W-1:0]   new_streak;
`endif

  // Outcome FIFO: push gated by the registered in_ready, so a push that
  // arrives while full is dropped even when a pop happens in the same cycle.
  always_comb begin
    push     = in_valid && in_ready_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_taken;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    in_ready_d = (occ_d != OCC_FULL);
  end

  // Transaction FSM, statistics and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cur_taken_d = cur_taken_q;
    pred_d      = pred_q;
    lat_cnt_d   = lat_cnt_q;
    total_cnt_d = total_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`ifdef MISS_STREAK_EN
    cur_streak_d = cur_streak_q;
    max_streak_d = max_streak_q;
    new_streak   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        // No bypass: occupancy is the registered count, so a fresh push is
        // only visible here from the following cycle.
        if (occ_q != '0) begin
          pop         = 1'b1;
          cur_taken_d = mem_q[rd_ptr_q];
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        pred_d    = prediction;
        lat_cnt_d = LAT_W'(RESOLVE_LAT);
        state_d   = (RESOLVE_LAT == 0) ? S_RES : S_RESOLVE;
      end
      S_RESOLVE: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q <= LAT_W'(1)) begin
          state_d = S_RES;
        end
      end
      S_RES: begin
        state_d     = S_IDLE;
        total_cnt_d = sat_inc(total_cnt_q);
        if (pred_q != cur_taken_q) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
`ifdef MISS_STREAK_EN
        new_streak   = (pred_q != cur_taken_q) ? sat_inc(cur_streak_q) : '0;
        cur_streak_d = new_streak;
        max_streak_d = (new_streak > max_streak_q) ? new_streak : max_streak_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    request_d    = (state_d == S_REQ);
    result_d     = (state_d == S_RES);
    taken_d      = (state_d == S_RES) && cur_taken_d;
    busy_d       = (state_d != S_IDLE);
    miss_pulse_d = (state_d == S_RES) && (pred_d != cur_taken_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      cur_taken_q  <= 1'b0;
      pred_q       <= 1'b0;
      lat_cnt_q    <= '0;
      total_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      in_ready_q   <= 1'b1;
      request_q    <= 1'b0;
      result_q     <= 1'b0;
      taken_q      <= 1'b0;
      busy_q       <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      cur_taken_q  <= cur_taken_d;
      pred_q       <= pred_d;
      lat_cnt_q    <= lat_cnt_d;
      total_cnt_q  <= total_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      in_ready_q   <= in_ready_d;
      request_q    <= request_d;
      result_q     <= result_d;
      taken_q      <= taken_d;
      busy_q       <= busy_d;
      miss_pulse_q <= miss_pulse_d;
    end
  end

`ifdef MISS_STREAK_EN
  // Miss-streak tracker registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_streak_q <= '0;
      max_streak_q <= '0;
    end else begin
      cur_streak_q <= cur_streak_d;
      max_streak_q <= max_streak_d;
    end
  end

  assign max_streak = max_streak_q;
`endif

  assign in_ready   = in_ready_q;
  assign request    = request_q;
  assign result     = result_q;
  assign taken      = taken_q;
  assign busy       = busy_q;
  assign miss_pulse = miss_pulse_q;
  assign total_cnt  = total_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_requester.sv
// Randomized bench for branch_requester. Two instances are driven from one
// shared outcome stream: a default one (DEPTH 4, latency 2, 16-bit counters)
// and a small one (DEPTH 2, latency 0, 3-bit counters, so the counters
// saturate). Each instance has its own 2-bit saturating-counter predictor.
// A transaction-level reference model predicts every output cycle by cycle.
// It keeps a queue of accepted outcomes and counts the cycles elapsed since
// each pop.

module tb_branch_requester;

  localparam int NI = 2;
  localparam int LAT [NI] = '{2, 0};
  localparam int DEP [NI] = '{4, 2};
  localparam int CMAX[NI] = '{65535, 7};

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_taken;
  logic pred_in [NI];
  logic rdy [NI];
  logic req [NI];
  logic res [NI];
  logic tkn [NI];
  logic bsy [NI];
  logic mp  [NI];
  logic [15:0] tot0, mis0;
  logic [2:0]  tot1, mis1;
`ifdef MISS_STREAK_EN
  logic [15:0] ms0;
  logic [2:0]  ms1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state.
  bit mq [NI][$];
  int age  [NI];
  bit cur  [NI];
  bit mpred[NI];
  int tot  [NI];
  int mis  [NI];
  int cstr [NI];
  int mstr [NI];
  int pctr [NI];

  always #5 clk = ~clk;

  branch_requester #(.DEPTH(4), .RESOLVE_LAT(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_taken(in_taken),
    .in_ready(rdy[0]), .request(req[0]), .prediction(pred_in[0]),
    .result(res[0]), .taken(tkn[0]), .busy(bsy[0]), .miss_pulse(mp[0]),
    .total_cnt(tot0), .miss_cnt(mis0)
`ifdef MISS_STREAK_EN
    , .max_streak(ms0)
`endif
  );

  branch_requester #(.DEPTH(2), .RESOLVE_LAT(0), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_taken(in_taken),
    .in_ready(rdy[1]), .request(req[1]), .prediction(pred_in[1]),
    .result(res[1]), .taken(tkn[1]), .busy(bsy[1]), .miss_pulse(mp[1]),
    .total_cnt(tot1), .miss_cnt(mis1)
`ifdef MISS_STREAK_EN
    , .max_streak(ms1)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      age[i]  = 0;
      cur[i]  = 1'b0;
      mpred[i] = 1'b0;
      tot[i]  = 0;
      mis[i]  = 0;
      cstr[i] = 0;
      mstr[i] = 0;
    end
  endtask

  task automatic check_outputs(input int i);
    bit exp_res;
    int got_tot, got_mis;
    exp_res = (age[i] == LAT[i] + 3);
    got_tot = (i == 0) ? int'(tot0) : int'(tot1);
    got_mis = (i == 0) ? int'(mis0) : int'(mis1);
    check($sformatf("in_ready%0d", i), int'(rdy[i]), int'(mq[i].size() < DEP[i]));
    check($sformatf("request%0d", i), int'(req[i]), int'(age[i] == 1));
    check($sformatf("result%0d", i), int'(res[i]), int'(exp_res));
    check($sformatf("taken%0d", i), int'(tkn[i]), int'(exp_res && cur[i]));
    check($sformatf("busy%0d", i), int'(bsy[i]), int'(age[i] > 0));
    check($sformatf("miss_pulse%0d", i), int'(mp[i]), int'(exp_res && (mpred[i] != cur[i])));
    check($sformatf("total_cnt%0d", i), got_tot, tot[i]);
    check($sformatf("miss_cnt%0d", i), got_mis, mis[i]);
`ifdef MISS_STREAK_EN
    check($sformatf("max_streak%0d", i), (i == 0) ? int'(ms0) : int'(ms1), mstr[i]);
`endif
  endtask

  // One clock cycle: sample at the falling edge, drive the next inputs,
  // then advance the model across the coming rising edge.
  task automatic step(input int pv, input bit rst_val);
    bit can_push [NI];
    bit miss;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check_outputs(i);

    reset    = rst_val;
    in_valid = ($urandom_range(99) < pv);
    in_taken = 1'(($urandom & 1));
    for (int i = 0; i < NI; i++) begin
      // Predictor output is only meaningful in the cycle after request.
      if (age[i] == 2) begin
        pred_in[i] = (pctr[i] >= 2);
        mpred[i]   = pred_in[i];
      end else begin
        pred_in[i] = 1'(($urandom & 1));
      end
    end

    if (rst_val) begin
      model_reset();
      return;
    end

    for (int i = 0; i < NI; i++) begin
      can_push[i] = (mq[i].size() < DEP[i]);
      if (age[i] == LAT[i] + 3) begin
        miss   = (mpred[i] != cur[i]);
        tot[i] = sat(tot[i], CMAX[i]);
        if (miss) begin
          mis[i]  = sat(mis[i], CMAX[i]);
          cstr[i] = sat(cstr[i], CMAX[i]);
        end else begin
          cstr[i] = 0;
        end
        if (cstr[i] > mstr[i]) mstr[i] = cstr[i];
        pctr[i] = cur[i] ? ((pctr[i] == 3) ? 3 : pctr[i] + 1)
                         : ((pctr[i] == 0) ? 0 : pctr[i] - 1);
        age[i] = 0;
      end else if (age[i] > 0) begin
        age[i]++;
      end else if (mq[i].size() > 0) begin
        cur[i] = mq[i].pop_front();
        age[i] = 1;
      end
      if (in_valid && can_push[i]) mq[i].push_back(in_taken);
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("arst_request%0d", i), int'(req[i]), 0);
      check($sformatf("arst_result%0d", i), int'(res[i]), 0);
      check($sformatf("arst_busy%0d", i), int'(bsy[i]), 0);
      check($sformatf("arst_in_ready%0d", i), int'(rdy[i]), 1);
    end
    check("arst_total0", int'(tot0), 0);
    check("arst_miss0", int'(mis0), 0);
    check("arst_total1", int'(tot1), 0);
    check("arst_miss1", int'(mis1), 0);
    model_reset();
  endtask

  initial begin
    bit hit;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_taken = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pred_in[i] = 1'b0;
      pctr[i]    = 3;
    end
    model_reset();

    step(0, 1'b1);
    step(0, 1'b1);
    step(70, 1'b0);
    for (int k = 0; k < 400; k++) step(70, 1'b0);

    // Reset while instance 0 is in its resolve wait.
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      if (age[0] == 3 && $urandom_range(1) == 0) hit = 1'b1;
      else step(90, 1'b0);
    end
    check("reach_resolve", int'(hit || age[0] == 3), 1);
    async_reset_check();
    step(60, 1'b1);
    step(60, 1'b0);

    for (int k = 0; k < 400; k++) step(15, 1'b0);
    for (int k = 0; k < 400; k++) step(97, 1'b0);
    for (int k = 0; k < 60; k++) step(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
